// File: rtl/recirc_mode_ctrl.sv
// recirc_mode_ctrl: gap-safe recirculation select for the four-lane demux, with timeout/force escape and beat counter.
module recirc_mode_ctrl #(
  parameter int GAP_CYCLES = 4,
  parameter int MAX_WAIT   = 255,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode_req_i,
  input  logic             force_i,
  input  logic             clr_cnt_i,
  input  logic             valid0_i,
  input  logic             valid1_i,
  input  logic             valid2_i,
  input  logic             valid3_i,
  output logic             recirculacion_o,
  output logic             switch_pending_o,
  output logic             mode_ack_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] recirc_beats_o
);
  localparam logic [1:0] PROBE  = 2'b00;
  localparam logic [1:0] WAIT_R = 2'b01;
  localparam logic [1:0] RECIRC = 2'b10;
  localparam logic [1:0] WAIT_P = 2'b11;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int SW = CNT_W + 1;

  logic [1:0]       state_q, state_d;
  logic [GW-1:0]    gap_q, gap_d, gap_nx;
  logic [WW-1:0]    wait_q, wait_d, wait_nx;
  logic             ack_q, tmo_q, tmo_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic [2:0]       pop;
  logic [CNT_W:0]   sum;
  logic             sel, waiting, idle, withdraw, gap_done, expire, sw;

  always_comb begin
    sel      = (state_q == RECIRC) || (state_q == WAIT_P);
    waiting  = (state_q == WAIT_R) || (state_q == WAIT_P);
    idle     = ~(valid0_i | valid1_i | valid2_i | valid3_i);
    gap_nx   = idle ? gap_q + GW'(1) : '0;
    wait_nx  = wait_q + WW'(1);
    withdraw = mode_req_i == sel;
    gap_done = gap_nx == GW'(GAP_CYCLES);
    expire   = wait_nx == WW'(MAX_WAIT);
    // gap beats force beats expiry, so timeout only records a true MAX_WAIT escape
    sw       = waiting & ~withdraw & (gap_done | force_i | expire);
    state_d  = waiting ? (withdraw ? (sel ? RECIRC : PROBE) : sw ? (sel ? PROBE : RECIRC) : state_q)
                       : (withdraw ? state_q : (sel ? WAIT_P : WAIT_R));
    gap_d    = waiting ? gap_nx : '0;
    wait_d   = waiting ? wait_nx : '0;
    tmo_d    = clr_cnt_i ? 1'b0 : tmo_q | (sw & ~gap_done & ~force_i);
    pop      = 3'(valid0_i) + 3'(valid1_i) + 3'(valid2_i) + 3'(valid3_i);
    sum      = {1'b0, beats_q} + SW'(pop);
    beats_d  = clr_cnt_i ? '0 : !sel ? beats_q : sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PROBE;
      gap_q   <= '0;
      wait_q  <= '0;
      ack_q   <= 1'b0;
      tmo_q   <= 1'b0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      wait_q  <= wait_d;
      ack_q   <= sw;
      tmo_q   <= tmo_d;
      beats_q <= beats_d;
    end
  end

  assign recirculacion_o  = sel;
  assign switch_pending_o = waiting;
  assign mode_ack_o       = ack_q;
  assign timeout_o        = tmo_q;
  assign recirc_beats_o   = beats_q;
endmodule
